// File: rtl/id_ex_latch_if.sv
// ID/EX stage bundle: ID-side inputs (i_*) and registered EX-side outputs (o_*).
// The master modport is the ID/control side, the slave modport is the latch.
interface id_ex_latch_if #(
    parameter int NB_DATA   = 32,
    parameter int NB_REG    = 5,
    parameter int NB_OPCODE = 6,
    parameter int NB_COUNT  = 16
) ();
    logic                 i_enable;
    logic                 i_flush;

    logic                 i_reg_dest;
    logic [NB_OPCODE-1:0] i_alu_op;
    logic                 i_alu_src;
    logic                 i_mem_read;
    logic                 i_mem_write;
    logic                 i_branch;
    logic                 i_reg_write;
    logic                 i_mem_to_reg;
    logic                 i_byte_en;
    logic                 i_halfword_en;
    logic                 i_word_en;
    logic                 i_jr_jalr;
    logic [NB_DATA-1:0]   i_pc;
    logic [NB_DATA-1:0]   i_data_a;
    logic [NB_DATA-1:0]   i_data_b;
    logic [NB_DATA-1:0]   i_extension;
    logic [NB_REG-1:0]    i_rs;
    logic [NB_REG-1:0]    i_rt;
    logic [NB_REG-1:0]    i_rd;

    logic                 o_reg_dest;
    logic [NB_OPCODE-1:0] o_alu_op;
    logic                 o_alu_src;
    logic                 o_mem_read;
    logic                 o_mem_write;
    logic                 o_branch;
    logic                 o_reg_write;
    logic                 o_mem_to_reg;
    logic                 o_byte_en;
    logic                 o_halfword_en;
    logic                 o_word_en;
    logic                 o_jr_jalr;
    logic [NB_DATA-1:0]   o_pc;
    logic [NB_DATA-1:0]   o_data_a;
    logic [NB_DATA-1:0]   o_data_b;
    logic [NB_DATA-1:0]   o_extension;
    logic [NB_REG-1:0]    o_rs;
    logic [NB_REG-1:0]    o_rt;
    logic [NB_REG-1:0]    o_rd;
    logic                 o_valid;
    logic                 o_stall;
    logic [NB_COUNT-1:0]  o_stall_count;

    modport master (
        output i_enable, i_flush,
        output i_reg_dest, i_alu_op, i_alu_src, i_mem_read, i_mem_write,
        output i_branch, i_reg_write, i_mem_to_reg,
        output i_byte_en, i_halfword_en, i_word_en, i_jr_jalr,
        output i_pc, i_data_a, i_data_b, i_extension, i_rs, i_rt, i_rd,
        input  o_reg_dest, o_alu_op, o_alu_src, o_mem_read, o_mem_write,
        input  o_branch, o_reg_write, o_mem_to_reg,
        input  o_byte_en, o_halfword_en, o_word_en, o_jr_jalr,
        input  o_pc, o_data_a, o_data_b, o_extension, o_rs, o_rt, o_rd,
        input  o_valid, o_stall, o_stall_count
    );

    modport slave (
        input  i_enable, i_flush,
        input  i_reg_dest, i_alu_op, i_alu_src, i_mem_read, i_mem_write,
        input  i_branch, i_reg_write, i_mem_to_reg,
        input  i_byte_en, i_halfword_en, i_word_en, i_jr_jalr,
        input  i_pc, i_data_a, i_data_b, i_extension, i_rs, i_rt, i_rd,
        output o_reg_dest, o_alu_op, o_alu_src, o_mem_read, o_mem_write,
        output o_branch, o_reg_write, o_mem_to_reg,
        output o_byte_en, o_halfword_en, o_word_en, o_jr_jalr,
        output o_pc, o_data_a, o_data_b, o_extension, o_rs, o_rt, o_rd,
        output o_valid, o_stall, o_stall_count
    );
endinterface

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall or flush, and a saturating count of load-use bubbles for the debug unit.
module id_ex_latch #(
    parameter int NB_DATA   = 32,
    parameter int NB_REG    = 5,
    parameter int NB_OPCODE = 6,
    parameter int NB_COUNT  = 16
) (
    input  logic          i_clock,
    input  logic          i_reset,
    id_ex_latch_if.slave  bus
);

    typedef struct packed {
        logic                 reg_dest;
        logic [NB_OPCODE-1:0] alu_op;
        logic                 alu_src;
        logic                 mem_read;
        logic                 mem_write;
        logic                 branch;
        logic                 reg_write;
        logic                 mem_to_reg;
        logic                 byte_en;
        logic                 halfword_en;
        logic                 word_en;
        logic                 jr_jalr;
        logic [NB_DATA-1:0]   pc;
        logic [NB_DATA-1:0]   data_a;
        logic [NB_DATA-1:0]   data_b;
        logic [NB_DATA-1:0]   extension;
        logic [NB_REG-1:0]    rs;
        logic [NB_REG-1:0]    rt;
        logic [NB_REG-1:0]    rd;
    } stage_t;

    localparam logic [NB_COUNT-1:0] COUNT_ONE = {{(NB_COUNT-1){1'b0}}, 1'b1};
    localparam logic [NB_COUNT-1:0] COUNT_MAX = '1;

    stage_t              id_word;
    stage_t              stage_d;
    stage_t              stage_q;
    logic                valid_d;
    logic                valid_q;
    logic [NB_COUNT-1:0] count_d;
    logic [NB_COUNT-1:0] count_q;
    logic                rt_match;
    logic                stall_w;

    always_comb begin
        id_word             = '0;
        id_word.reg_dest    = bus.i_reg_dest;
        id_word.alu_op      = bus.i_alu_op;
        id_word.alu_src     = bus.i_alu_src;
        id_word.mem_read    = bus.i_mem_read;
        id_word.mem_write   = bus.i_mem_write;
        id_word.branch      = bus.i_branch;
        id_word.reg_write   = bus.i_reg_write;
        id_word.mem_to_reg  = bus.i_mem_to_reg;
        id_word.byte_en     = bus.i_byte_en;
        id_word.halfword_en = bus.i_halfword_en;
        id_word.word_en     = bus.i_word_en;
        id_word.jr_jalr     = bus.i_jr_jalr;
        id_word.pc          = bus.i_pc;
        id_word.data_a      = bus.i_data_a;
        id_word.data_b      = bus.i_data_b;
        id_word.extension   = bus.i_extension;
        id_word.rs          = bus.i_rs;
        id_word.rt          = bus.i_rt;
        id_word.rd          = bus.i_rd;
    end

    // A load in EX whose destination feeds either ID source must wait one cycle;
    // r0 is never a real dependency, and a bubble in EX is never a load.
    assign rt_match = (stage_q.rt == bus.i_rs) | (stage_q.rt == bus.i_rt);
    assign stall_w  = bus.i_enable & valid_q & stage_q.mem_read &
                      (stage_q.rt != '0) & rt_match;

    // Priority: hold when disabled, then flush bubble, then stall bubble, then load.
    always_comb begin
        stage_d = stage_q;
        valid_d = valid_q;
        count_d = count_q;
        if (bus.i_enable) begin
            if (bus.i_flush) begin
                stage_d = '0;
                valid_d = 1'b0;
            end else if (stall_w) begin
                stage_d = '0;
                valid_d = 1'b0;
                if (count_q != COUNT_MAX) begin
                    count_d = count_q + COUNT_ONE;
                end
            end else begin
                stage_d = id_word;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            stage_q <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign bus.o_reg_dest    = stage_q.reg_dest;
    assign bus.o_alu_op      = stage_q.alu_op;
    assign bus.o_alu_src     = stage_q.alu_src;
    assign bus.o_mem_read    = stage_q.mem_read;
    assign bus.o_mem_write   = stage_q.mem_write;
    assign bus.o_branch      = stage_q.branch;
    assign bus.o_reg_write   = stage_q.reg_write;
    assign bus.o_mem_to_reg  = stage_q.mem_to_reg;
    assign bus.o_byte_en     = stage_q.byte_en;
    assign bus.o_halfword_en = stage_q.halfword_en;
    assign bus.o_word_en     = stage_q.word_en;
    assign bus.o_jr_jalr     = stage_q.jr_jalr;
    assign bus.o_pc          = stage_q.pc;
    assign bus.o_data_a      = stage_q.data_a;
    assign bus.o_data_b      = stage_q.data_b;
    assign bus.o_extension   = stage_q.extension;
    assign bus.o_rs          = stage_q.rs;
    assign bus.o_rt          = stage_q.rt;
    assign bus.o_rd          = stage_q.rd;
    assign bus.o_valid       = valid_q;
    assign bus.o_stall       = stall_w;
    assign bus.o_stall_count = count_q;

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed bench for id_ex_latch: reset, load-use stall, false-stall guard,
// flush, enable hold and counter saturation (NB_COUNT = 2).
module tb_id_ex_latch;

    localparam int NB_DATA   = 32;
    localparam int NB_REG    = 5;
    localparam int NB_OPCODE = 6;
    localparam int NB_COUNT  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    id_ex_latch_if #(
        .NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_OPCODE(NB_OPCODE), .NB_COUNT(NB_COUNT)
    ) bus ();

    id_ex_latch #(
        .NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_OPCODE(NB_OPCODE), .NB_COUNT(NB_COUNT)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .bus(bus)
    );

    task automatic stepEdge;
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs;
        bus.i_enable = 1'b1;       bus.i_flush = 1'b0;
        bus.i_reg_dest = 1'b0;     bus.i_alu_op = '0;        bus.i_alu_src = 1'b0;
        bus.i_mem_read = 1'b0;     bus.i_mem_write = 1'b0;   bus.i_branch = 1'b0;
        bus.i_reg_write = 1'b0;    bus.i_mem_to_reg = 1'b0;  bus.i_byte_en = 1'b0;
        bus.i_halfword_en = 1'b0;  bus.i_word_en = 1'b0;     bus.i_jr_jalr = 1'b0;
        bus.i_pc = '0;             bus.i_data_a = '0;        bus.i_data_b = '0;
        bus.i_extension = '0;      bus.i_rs = '0;            bus.i_rt = '0;
        bus.i_rd = '0;
    endtask

    task automatic setLoad(input logic [NB_REG-1:0] rs, input logic [NB_REG-1:0] rt);
        clearInputs();
        bus.i_mem_read = 1'b1; bus.i_mem_to_reg = 1'b1; bus.i_reg_write = 1'b1;
        bus.i_alu_src = 1'b1;  bus.i_word_en = 1'b1;    bus.i_alu_op = 6'h23;
        bus.i_rs = rs;         bus.i_rt = rt;           bus.i_extension = 32'h4;
        bus.i_pc = 32'h0000_0040;
    endtask

    task automatic test_reset;
        clearInputs();
        bus.i_pc = $urandom; bus.i_data_a = $urandom; bus.i_data_b = $urandom;
        bus.i_rs = 5'd3; bus.i_rt = 5'd4; bus.i_reg_write = 1'b1; bus.i_alu_op = 6'h21;
        rst_n = 1'b0;
        stepEdge();
        stepEdge();
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_hold_valid got=%0h exp=0", bus.o_valid); end
        checks++; if (bus.o_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_hold_pc got=%0h exp=0", bus.o_pc); end
        rst_n = 1'b1;
        stepEdge();
        checks++; if (bus.o_valid !== 1'b1 || bus.o_alu_op !== 6'h21) begin failures++; $display("[TB] FAIL pre_reset_load got=%0h/%0h exp=1/21", bus.o_valid, bus.o_alu_op); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_valid got=%0h exp=0", bus.o_valid); end
        checks++; if (bus.o_data_a !== 32'h0 || bus.o_pc !== 32'h0) begin failures++; $display("[TB] FAIL async_reset_data got=%0h/%0h exp=0/0", bus.o_data_a, bus.o_pc); end
        checks++; if (bus.o_reg_write !== 1'b0 || bus.o_alu_op !== 6'h0 || bus.o_rt !== 5'd0) begin failures++; $display("[TB] FAIL async_reset_ctrl got=%0h/%0h/%0h exp=0/0/0", bus.o_reg_write, bus.o_alu_op, bus.o_rt); end
        checks++; if (bus.o_stall !== 1'b0 || bus.o_stall_count !== 2'd0) begin failures++; $display("[TB] FAIL async_reset_stall got=%0h/%0h exp=0/0", bus.o_stall, bus.o_stall_count); end
        rst_n = 1'b1;
        clearInputs();
        bus.i_rs = 5'd2; bus.i_rt = 5'd3; bus.i_extension = 32'd5;
        bus.i_alu_src = 1'b1; bus.i_reg_write = 1'b1; bus.i_alu_op = 6'h08; bus.i_pc = 32'h0000_0004;
        stepEdge();
        checks++; if (bus.o_valid !== 1'b1) begin failures++; $display("[TB] FAIL addi_valid got=%0h exp=1", bus.o_valid); end
        checks++; if (bus.o_rs !== 5'd2 || bus.o_rt !== 5'd3) begin failures++; $display("[TB] FAIL addi_regs got=%0d/%0d exp=2/3", bus.o_rs, bus.o_rt); end
        checks++; if (bus.o_extension !== 32'd5 || bus.o_pc !== 32'd4) begin failures++; $display("[TB] FAIL addi_imm_pc got=%0h/%0h exp=5/4", bus.o_extension, bus.o_pc); end
        checks++; if (bus.o_alu_op !== 6'h08 || bus.o_alu_src !== 1'b1 || bus.o_reg_write !== 1'b1) begin failures++; $display("[TB] FAIL addi_ctrl got=%0h/%0h/%0h exp=8/1/1", bus.o_alu_op, bus.o_alu_src, bus.o_reg_write); end
    endtask

    task automatic test_load_use;
        setLoad(5'd4, 5'd8);
        stepEdge();
        checks++; if (bus.o_mem_read !== 1'b1 || bus.o_rt !== 5'd8) begin failures++; $display("[TB] FAIL lw_captured got=%0h/%0d exp=1/8", bus.o_mem_read, bus.o_rt); end
        clearInputs();
        bus.i_rs = 5'd8; bus.i_rt = 5'd9; bus.i_rd = 5'd10; bus.i_reg_dest = 1'b1;
        bus.i_reg_write = 1'b1; bus.i_alu_op = 6'h20; bus.i_pc = 32'h0000_0044;
        #1;
        checks++; if (bus.o_stall !== 1'b1) begin failures++; $display("[TB] FAIL lu_stall got=%0h exp=1", bus.o_stall); end
        stepEdge();
        checks++; if (bus.o_valid !== 1'b0 || bus.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL lu_bubble got=%0h/%0h exp=0/0", bus.o_valid, bus.o_stall); end
        checks++; if (bus.o_mem_read !== 1'b0 || bus.o_reg_write !== 1'b0 || bus.o_word_en !== 1'b0 || bus.o_alu_op !== 6'h0 || bus.o_rt !== 5'd0) begin failures++; $display("[TB] FAIL lu_bubble_ctrl got=%0h/%0h/%0h/%0h/%0d exp=0/0/0/0/0", bus.o_mem_read, bus.o_reg_write, bus.o_word_en, bus.o_alu_op, bus.o_rt); end
        checks++; if (bus.o_stall_count !== 2'd1) begin failures++; $display("[TB] FAIL lu_count got=%0d exp=1", bus.o_stall_count); end
        stepEdge();
        checks++; if (bus.o_valid !== 1'b1 || bus.o_rs !== 5'd8 || bus.o_rd !== 5'd10 || bus.o_pc !== 32'h44) begin failures++; $display("[TB] FAIL lu_dependent got=%0h/%0d/%0d/%0h exp=1/8/10/44", bus.o_valid, bus.o_rs, bus.o_rd, bus.o_pc); end
    endtask

    task automatic test_no_false_stall;
        setLoad(5'd1, 5'd0);
        stepEdge();
        clearInputs();
        #1;
        checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL r0_no_stall got=%0h exp=0", bus.o_stall); end
        setLoad(5'd4, 5'd8);
        stepEdge();
        clearInputs();
        bus.i_rs = 5'd9; bus.i_rt = 5'd10;
        #1;
        checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL unrelated_no_stall got=%0h exp=0", bus.o_stall); end
        stepEdge();
        checks++; if (bus.o_valid !== 1'b1 || bus.o_rs !== 5'd9 || bus.o_stall_count !== 2'd1) begin failures++; $display("[TB] FAIL unrelated_load got=%0h/%0d/%0d exp=1/9/1", bus.o_valid, bus.o_rs, bus.o_stall_count); end
    endtask

    task automatic test_flush;
        clearInputs();
        bus.i_mem_write = 1'b1; bus.i_alu_src = 1'b1; bus.i_rs = 5'd5; bus.i_rt = 5'd6;
        bus.i_word_en = 1'b1; bus.i_pc = 32'h0000_0080; bus.i_flush = 1'b1;
        stepEdge();
        checks++; if (bus.o_mem_write !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_rt !== 5'd0 || bus.o_pc !== 32'h0) begin failures++; $display("[TB] FAIL flush_sw got=%0h/%0h/%0d/%0h exp=0/0/0/0", bus.o_mem_write, bus.o_valid, bus.o_rt, bus.o_pc); end
        setLoad(5'd4, 5'd8);
        stepEdge();
        clearInputs();
        bus.i_rs = 5'd8; bus.i_flush = 1'b1;
        #1;
        checks++; if (bus.o_stall !== 1'b1) begin failures++; $display("[TB] FAIL flush_hazard_stall got=%0h exp=1", bus.o_stall); end
        stepEdge();
        checks++; if (bus.o_valid !== 1'b0 || bus.o_mem_read !== 1'b0 || bus.o_stall_count !== 2'd1) begin failures++; $display("[TB] FAIL flush_hazard_bubble got=%0h/%0h/%0d exp=0/0/1", bus.o_valid, bus.o_mem_read, bus.o_stall_count); end
        bus.i_flush = 1'b0;
    endtask

    task automatic test_enable_hold;
        setLoad(5'd4, 5'd13);
        bus.i_pc = 32'h0000_0100; bus.i_data_a = 32'hDEAD_BEEF;
        stepEdge();
        clearInputs();
        bus.i_enable = 1'b0; bus.i_rs = 5'd13;
        #1;
        checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL disabled_stall got=%0h exp=0", bus.o_stall); end
        for (int k = 0; k < 3; k++) begin
            bus.i_pc = 32'h0000_0200 + 32'(k); bus.i_data_a = $urandom; bus.i_rt = 5'(k + 1);
            stepEdge();
            checks++; if (bus.o_pc !== 32'h100 || bus.o_data_a !== 32'hDEAD_BEEF || bus.o_rt !== 5'd13 || bus.o_valid !== 1'b1 || bus.o_mem_read !== 1'b1 || bus.o_stall !== 1'b0) begin failures++; $display("[TB] FAIL hold_%0d got=%0h/%0h/%0d/%0h/%0h exp=100/deadbeef/13/1/0", k, bus.o_pc, bus.o_data_a, bus.o_rt, bus.o_valid, bus.o_stall); end
        end
        clearInputs();
        bus.i_rs = 5'd1; bus.i_rt = 5'd2; bus.i_pc = 32'h0000_0300; bus.i_branch = 1'b1;
        stepEdge();
        checks++; if (bus.o_pc !== 32'h300 || bus.o_rs !== 5'd1 || bus.o_branch !== 1'b1 || bus.o_mem_read !== 1'b0 || bus.o_stall_count !== 2'd1) begin failures++; $display("[TB] FAIL reenable_load got=%0h/%0d/%0h/%0h/%0d exp=300/1/1/0/1", bus.o_pc, bus.o_rs, bus.o_branch, bus.o_mem_read, bus.o_stall_count); end
    endtask

    task automatic test_saturation;
        logic [NB_COUNT-1:0] expCount;
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            setLoad(5'd4, 5'd8);
            stepEdge();
            clearInputs();
            bus.i_rs = 5'd8;
            stepEdge();
            expCount = (k < 3) ? NB_COUNT'(k + 1) : 2'd3;
            checks++; if (bus.o_stall_count !== expCount || bus.o_valid !== 1'b0) begin failures++; $display("[TB] FAIL sat_%0d got=%0d/%0h exp=%0d/0", k, bus.o_stall_count, bus.o_valid, expCount); end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clearInputs();
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_flush();
        test_enable_hold();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
